// File: rtl/iir_lowpass_biquad.sv
// iir_lowpass_biquad
// Second-order low-pass IIR (direct form I) on a 32-bit signed sample stream.
// Every rising edge with reset low consumes one sample and produces one
// registered output sample. The arithmetic is bit-exact fixed point: full-width
// signed products, a wide accumulator with no intermediate truncation,
// round-half-up by FRAC bits and saturation to the output range.
// Defaults implement a Butterworth LPF with fc = 1 kHz at fs = 44.1 kHz
// (coefficients in Q2.30).
//
// Ports
//   clk     in   1    clock, all state updates on the rising edge
//   reset   in   1    synchronous active-high reset, clears all history
//   Input   in   DW   signed input sample x[n]
//   Output  out  DW   signed filtered sample y[n], registered (1 cycle latency)
module iir_lowpass_biquad #(
    parameter int unsigned          DW   = 32,
    parameter int unsigned          CW   = 32,
    parameter int unsigned          FRAC = 30,
    parameter logic signed [CW-1:0] B0   = 32'sd4943508,
    parameter logic signed [CW-1:0] B1   = 32'sd9887015,
    parameter logic signed [CW-1:0] B2   = 32'sd4943508,
    parameter logic signed [CW-1:0] A1   = -32'sd1931762473,
    parameter logic signed [CW-1:0] A2   = 32'sd877795752
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] Input,
    output logic signed [DW-1:0] Output
);

    // Product width, and accumulator width with headroom for five terms.
    localparam int unsigned PW = DW + CW;
    localparam int unsigned AW = PW + 3;

    localparam logic signed [AW-1:0] RoundC =
        {{(AW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    localparam logic signed [AW-1:0] SatMax =
        {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin =
        {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    logic signed [DW-1:0] x1_q, x2_q;
    logic signed [DW-1:0] y1_q, y2_q;
    logic signed [DW-1:0] y_d;

    logic signed [PW-1:0] p0, p1, p2, p3, p4;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] r;

    always_comb begin
        // Operands are sign-extended to the product width so each product is exact.
        p0 = PW'(B0) * PW'(Input);
        p1 = PW'(B1) * PW'(x1_q);
        p2 = PW'(B2) * PW'(x2_q);
        p3 = PW'(A1) * PW'(y1_q);
        p4 = PW'(A2) * PW'(y2_q);

        acc = AW'(p0) + AW'(p1) + AW'(p2) - AW'(p3) - AW'(p4);

        // Arithmetic shift of (acc + half) rounds half toward +inf.
        r = (acc + RoundC) >>> FRAC;

        if (r > SatMax) begin
            y_d = {1'b0, {(DW - 1){1'b1}}};
        end else if (r < SatMin) begin
            y_d = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            y_d = r[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            x1_q <= Input;
            x2_q <= x1_q;
            y1_q <= y_d;
            y2_q <= y1_q;
        end
    end

    // The output register and y[n-1] always hold the same saturated value,
    // so one register serves both.
    assign Output = y1_q;

endmodule

// File: tb/tb_iir_lowpass_biquad.sv
module tb_iir_lowpass_biquad;

    localparam longint CB0 = 64'sd4943508;
    localparam longint CB1 = 64'sd9887015;
    localparam longint CB2 = 64'sd4943508;
    localparam longint CA1 = -64'sd1931762473;
    localparam longint CA2 = 64'sd877795752;

    logic               clk;
    logic               reset;
    logic signed [31:0] x_in;
    logic signed [31:0] y_out;

    int total;
    int bad;

    iir_lowpass_biquad dut (
        .clk    (clk),
        .reset  (reset),
        .Input  (x_in),
        .Output (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden arithmetic: exact wide sum, round half up, saturate.
    function automatic logic signed [31:0] golden(
        input logic signed [31:0] x0, input logic signed [31:0] x1,
        input logic signed [31:0] x2, input logic signed [31:0] y1,
        input logic signed [31:0] y2);
        logic signed [127:0] acc;
        logic signed [127:0] r;
        longint p0, p1, p2, p3, p4;
        p0 = CB0 * longint'(x0);
        p1 = CB1 * longint'(x1);
        p2 = CB2 * longint'(x2);
        p3 = CA1 * longint'(y1);
        p4 = CA2 * longint'(y2);
        acc = 128'(p0) + 128'(p1) + 128'(p2) - 128'(p3) - 128'(p4);
        r = (acc + 128'sd536870912) >>> 30;
        if (r > 128'sd2147483647) return 32'sh7FFFFFFF;
        if (r < -128'sd2147483648) return 32'sh80000000;
        return r[31:0];
    endfunction

    // Reference model: history of accepted samples since the last reset.
    logic signed [31:0] xs[$];
    logic signed [31:0] ys[$];
    logic signed [31:0] exp_y;
    bit                 model_valid = 1'b0;

    always @(posedge clk) begin
        logic signed [31:0] x1, x2, y1, y2;
        if (reset) begin
            xs.delete();
            ys.delete();
            exp_y = 32'sd0;
        end else begin
            x1 = (xs.size() >= 1) ? xs[$]   : 32'sd0;
            x2 = (xs.size() >= 2) ? xs[$-1] : 32'sd0;
            y1 = (ys.size() >= 1) ? ys[$]   : 32'sd0;
            y2 = (ys.size() >= 2) ? ys[$-1] : 32'sd0;
            exp_y = golden(x_in, x1, x2, y1, y2);
            xs.push_back(x_in);
            ys.push_back(exp_y);
            if (xs.size() > 2) void'(xs.pop_front());
            if (ys.size() > 2) void'(ys.pop_front());
        end
        model_valid = 1'b1;
    end

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input longint val);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: observed=%0d outside required bound", name, val);
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (model_valid) check("model_vs_dut", y_out, exp_y);
    end

    // Drive one sample (called at a negedge or time 0), return at the next negedge.
    task automatic cycle(input bit rst, input logic signed [31:0] x);
        reset = rst;
        x_in  = x;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        longint ymax, ymin, worst;
        bit     saw_clip, saw_wrong_sign;
        total = 0;
        bad   = 0;

        // Reset held for three edges with a non-zero input.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'sd12345);
            check("reset_output_zero", y_out, 32'sd0);
        end

        // Impulse straight out of reset: first output depends only on the new input.
        cycle(1'b0, 32'sd1048576);
        check("impulse_y0", y_out, 32'sd4828);
        check("impulse_model_y0", exp_y, 32'sd4828);
        cycle(1'b0, 32'sd0);
        check("impulse_y1", y_out, 32'sd18341);
        check("impulse_model_y1", exp_y, 32'sd18341);
        worst = 0;
        for (int i = 2; i < 400; i++) begin
            cycle(1'b0, 32'sd0);
            if (i >= 300 && (longint'(y_out) > worst || -longint'(y_out) > worst))
                worst = (y_out < 0) ? -longint'(y_out) : longint'(y_out);
        end
        // Rounding deadband can leave the tail resting on a small constant.
        check_true("impulse_tail_small", worst <= 32, worst);

        // Step to DC.
        cycle(1'b1, 32'sd0);
        ymax = -64'sd1;
        for (int i = 0; i < 2000; i++) begin
            cycle(1'b0, 32'sd1000000);
            if (longint'(y_out) > ymax) ymax = longint'(y_out);
        end
        check_true("step_overshoot_below_5pct", ymax < 1050000, ymax);
        check_true("step_has_overshoot", ymax > 1000000, ymax);
        check_true("step_settled", y_out > 999900 && y_out < 1000100, longint'(y_out));
        ymax = longint'(y_out);
        ymin = longint'(y_out);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 32'sd1000000);
            if (longint'(y_out) > ymax) ymax = longint'(y_out);
            if (longint'(y_out) < ymin) ymin = longint'(y_out);
        end
        check_true("step_no_oscillation", (ymax - ymin) <= 8, ymax - ymin);

        // Positive full scale: must clip at max during overshoot, never go negative.
        cycle(1'b1, 32'sd0);
        saw_clip = 1'b0;
        saw_wrong_sign = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 32'sh7FFFFFFF);
            if (y_out == 32'sh7FFFFFFF) saw_clip = 1'b1;
            if (y_out < 0) saw_wrong_sign = 1'b1;
        end
        check_true("sat_pos_clipped", saw_clip, longint'(y_out));
        check_true("sat_pos_never_negative", !saw_wrong_sign, longint'(y_out));

        // Negative full scale.
        cycle(1'b1, 32'sd0);
        saw_clip = 1'b0;
        saw_wrong_sign = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 32'sh80000000);
            if (y_out == 32'sh80000000) saw_clip = 1'b1;
            if (y_out > 0) saw_wrong_sign = 1'b1;
        end
        check_true("sat_neg_clipped", saw_clip, longint'(y_out));
        check_true("sat_neg_never_positive", !saw_wrong_sign, longint'(y_out));

        // Nyquist-rate input is fully rejected.
        cycle(1'b1, 32'sd0);
        worst = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, (i % 2 == 0) ? 32'sd1000000 : -32'sd1000000);
            if (i >= 300) begin
                if (longint'(y_out) > worst) worst = longint'(y_out);
                if (-longint'(y_out) > worst) worst = -longint'(y_out);
            end
        end
        check_true("nyquist_rejected", worst < 2000, worst);

        // Random stream, full-scale and audio-level segments, one reset mid-stream.
        for (int i = 0; i < 20000; i++) begin
            logic signed [31:0] x;
            x = $signed($urandom());
            if ((i / 500) % 2 == 1) x = x >>> 10;
            cycle((i >= 10000 && i < 10002), x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
